randomness_reuse_shuffler: RTL and testbench

Parametrised randomness distributor for masked cipher datapaths. Accepts a W-bit fresh-randomness word from the PRNG over a valid/ready handshake and holds it in a register. It presents NCH rotated copies to the masked S-box instances, and re-rotates the held word on each round-advance pulse so one fresh word serves up to MAX_REUSE+1 rounds before a refill. It sits between the PRNG and the round function of the masked PRINCE cores.

---
 rtl/randomness_reuse_shuffler.sv | 138 +++++++++++++
 tb/tb_randomness_reuse_shuffler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/randomness_reuse_shuffler.sv
// -----------------------------------------------------------------------------
// randomness_reuse_shuffler
//
// Holds one fresh W-bit randomness word from the PRNG and presents NCH rotated
// copies of it to the masked S-box share groups. Each round-advance pulse
// re-rotates the held word, so a single fresh word serves up to MAX_REUSE+1
// rounds before a refill is requested.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   rnd_in      in   [W-1:0]     fresh randomness from the PRNG
//   rnd_valid   in   rnd_in valid
//   rnd_ready   out  word accepted this cycle (combinational on adv)
//   adv         in   round-advance pulse, consumes the current presentation
//   out_valid   out  shuffle_r carries valid randomness
//   shuffle_r   out  [NCH*W-1:0] channel k at bits [k*W +: W]
//   reuse_cnt   out  [CW-1:0]    reuses already applied to the held word
//   starve      out  sticky flag: adv arrived while no word was held
//   clr_starve  in   synchronous clear of starve (a new starve event wins)
// -----------------------------------------------------------------------------
module randomness_reuse_shuffler #(
    parameter int W         = 188,
    parameter int NCH       = 4,
    parameter int OFFSET    = 16,
    parameter int STEP      = 8,
    parameter int MAX_REUSE = 3,
    localparam int CW       = (MAX_REUSE > 0) ? $clog2(MAX_REUSE + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     rnd_in,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic             adv,
    output logic             out_valid,
    output logic [NCH*W-1:0] shuffle_r,
    output logic [CW-1:0]    reuse_cnt,
    output logic             starve,
    input  logic             clr_starve
);

    // Rotation amounts live in [0, W-1]; one extra bit holds an unreduced sum.
    localparam int RW = $clog2(W);
    localparam logic [RW:0] W_EXT    = (RW + 1)'(W);
    localparam logic [RW:0] STEP_EXT = (RW + 1)'(STEP);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e          state_q;
    logic [W-1:0]    base_q;
    logic [RW-1:0]   rot_q;
    logic [CW-1:0]   reuse_q;
    logic            starve_q;

    // Static per-channel distance k*OFFSET mod W, reduced by repeated
    // conditional subtraction so no divider is elaborated.
    function automatic int chan_off(input int k);
        int acc;
        acc = 0;
        for (int i = 0; i < k; i++) begin
            acc = acc + OFFSET;
            if (acc >= W) acc = acc - W;
        end
        return acc;
    endfunction

    logic          exhausted;
    logic          load;
    logic [RW:0]   rot_sum;
    logic [RW-1:0] rot_adv_d;

    assign exhausted = (reuse_q == CW'(MAX_REUSE));

    // A full, exhausted word frees the register in the same cycle adv consumes
    // it, which allows back-to-back refills without an out_valid bubble. This
    // makes rnd_ready combinational on adv.
    assign rnd_ready = (state_q == ST_EMPTY) || (adv && exhausted);
    assign load      = rnd_valid && rnd_ready;

    // rot and STEP are both below W, so one conditional subtract wraps the sum.
    assign rot_sum   = {1'b0, rot_q} + STEP_EXT;
    assign rot_adv_d = (rot_sum >= W_EXT) ? RW'(rot_sum - W_EXT) : rot_sum[RW-1:0];

    // NOTE: every register, including the wide base word, takes the async
    // reset so a partially reused word can never leak out after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            base_q   <= '0;
            rot_q    <= '0;
            reuse_q  <= '0;
            starve_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update here
            // based on the pre-edge values, independent of statement order.
            starve_q <= (starve_q && !clr_starve) || (adv && (state_q == ST_EMPTY));

            if (load) begin
                base_q  <= rnd_in;
                rot_q   <= '0;
                reuse_q <= '0;
                state_q <= ST_FULL;
            end else if ((state_q == ST_FULL) && adv) begin
                if (!exhausted) begin
                    reuse_q <= reuse_q + CW'(1);
                    rot_q   <= rot_adv_d;
                end else begin
                    // base is kept but no longer presented.
                    state_q <= ST_EMPTY;
                end
            end
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign reuse_cnt = reuse_q;
    assign starve    = starve_q;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        localparam logic [RW:0] CH_OFF = (RW + 1)'(chan_off(k));

        logic [RW:0] r_sum;
        logic [RW:0] r_amt;

        assign r_sum = {1'b0, rot_q} + CH_OFF;
        assign r_amt = (r_sum >= W_EXT) ? (r_sum - W_EXT) : r_sum;

        // Rotate right by r_amt; for r_amt==0 the left shift by W yields zero.
        assign shuffle_r[k*W +: W] = (state_q == ST_FULL)
                                   ? ((base_q >> r_amt) | (base_q << (W_EXT - r_amt)))
                                   : '0;
    end

endmodule

// File: tb/tb_randomness_reuse_shuffler.sv
// -----------------------------------------------------------------------------
// tb_randomness_reuse_shuffler
//
// Self-checking bench: a default-parameter instance driven by directed and
// random stimulus against a behavioural model, plus a small W=16 instance for
// the rotation wrap-around sequence.
// -----------------------------------------------------------------------------
module tb_randomness_reuse_shuffler;

    localparam int W         = 188;
    localparam int NCH       = 4;
    localparam int OFFSET    = 16;
    localparam int STEP      = 8;
    localparam int MAX_REUSE = 3;
    localparam int CW        = 2;
    localparam int SW        = NCH * W;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  rnd_in;
    logic          rnd_valid;
    logic          rnd_ready;
    logic          adv;
    logic          out_valid;
    logic [SW-1:0] shuffle_r;
    logic [CW-1:0] reuse_cnt;
    logic          starve;
    logic          clr_starve;

    // Small instance: W=16, STEP=12, OFFSET=4, MAX_REUSE=3.
    logic [15:0]   s_rnd_in;
    logic          s_rnd_valid;
    logic          s_rnd_ready;
    logic          s_adv;
    logic          s_out_valid;
    logic [63:0]   s_shuffle;
    logic [1:0]    s_reuse;
    logic          s_starve;
    logic          s_clr;

    randomness_reuse_shuffler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rnd_in     (rnd_in),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .adv        (adv),
        .out_valid  (out_valid),
        .shuffle_r  (shuffle_r),
        .reuse_cnt  (reuse_cnt),
        .starve     (starve),
        .clr_starve (clr_starve)
    );

    randomness_reuse_shuffler #(
        .W(16), .NCH(4), .OFFSET(4), .STEP(12), .MAX_REUSE(3)
    ) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .rnd_in     (s_rnd_in),
        .rnd_valid  (s_rnd_valid),
        .rnd_ready  (s_rnd_ready),
        .adv        (s_adv),
        .out_valid  (s_out_valid),
        .shuffle_r  (s_shuffle),
        .reuse_cnt  (s_reuse),
        .starve     (s_starve),
        .clr_starve (s_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_full;
    logic [W-1:0] m_base;
    int           m_uses;
    bit           m_starve;

    function automatic void m_reset();
        m_full   = 1'b0;
        m_base   = '0;
        m_uses   = 0;
        m_starve = 1'b0;
    endfunction

    function automatic bit m_ready(input bit a);
        return !m_full || (a && (m_uses == MAX_REUSE));
    endfunction

    function automatic void m_step(input bit v, input logic [W-1:0] d, input bit a, input bit c);
        bit was_empty;
        bit ready;
        was_empty = !m_full;
        ready     = m_ready(a);
        m_starve  = (m_starve && !c) || (a && was_empty);
        if (v && ready) begin
            m_full = 1'b1;
            m_base = d;
            m_uses = 0;
        end else if (m_full && a) begin
            if (m_uses < MAX_REUSE) m_uses++;
            else                    m_full = 1'b0;
        end
    endfunction

    // Channel k is the held word rotated right by (uses*STEP + k*OFFSET) mod W.
    function automatic logic [SW-1:0] exp_shuffle();
        logic [SW-1:0] e;
        int r;
        e = '0;
        if (m_full) begin
            for (int k = 0; k < NCH; k++) begin
                r = (m_uses * STEP + k * OFFSET) % W;
                for (int i = 0; i < W; i++) e[k*W + i] = m_base[(i + r) % W];
            end
        end
        return e;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[i] = 1'($urandom_range(0, 1));
        return w;
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] v, input int r);
        logic [15:0] o;
        for (int i = 0; i < 16; i++) o[i] = v[(i + r) % 16];
        return o;
    endfunction

    task automatic compare_outputs();
        check("out_valid", out_valid, m_full);
        check("reuse_cnt", reuse_cnt, m_uses);
        check("starve",    starve,    m_starve);
        check("shuffle_r", shuffle_r, exp_shuffle());
    endtask

    // Called just after a falling edge: drive, check rnd_ready, clock, compare.
    task automatic drive_cycle(input bit v, input logic [W-1:0] d, input bit a, input bit c);
        rnd_valid  = v;
        rnd_in     = d;
        adv        = a;
        clr_starve = c;
        #1;
        check("rnd_ready", rnd_ready, m_ready(a));
        @(posedge clk);
        m_step(v, d, a, c);
        @(negedge clk);
        compare_outputs();
    endtask

    int rot_seq [4] = '{0, 12, 8, 4};
    int ch3_seq [4] = '{12, 8, 4, 0};

    initial begin
        logic [SW-1:0] e_map;
        logic [W-1:0]  c_exp;

        rst_n = 1'b1;
        rnd_in = '0; rnd_valid = 1'b0; adv = 1'b0; clr_starve = 1'b0;
        s_rnd_in = '0; s_rnd_valid = 1'b0; s_adv = 1'b0; s_clr = 1'b0;
        m_reset();

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_shuffle",   shuffle_r, 0);
        check("rst_ready",     rnd_ready, 1);
        check("rst_reuse",     reuse_cnt, 0);
        check("rst_starve",    starve,    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Channel mapping with a single set bit.
        drive_cycle(1'b1, W'(1), 1'b0, 1'b0);
        e_map = '0;
        e_map[0] = 1'b1;
        e_map[W + 172] = 1'b1;
        e_map[2*W + 156] = 1'b1;
        e_map[3*W + 140] = 1'b1;
        check("map_default", shuffle_r, e_map);

        // One reuse: rot=8.
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        c_exp = '0; c_exp[180] = 1'b1;
        check("adv1_ch0", shuffle_r[0 +: W], c_exp);
        c_exp = '0; c_exp[132] = 1'b1;
        check("adv1_ch3", shuffle_r[3*W +: W], c_exp);
        check("adv1_reuse", reuse_cnt, 1);

        // Exhaustion without refill: fourth adv empties the block.
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        check("exhaust_valid", out_valid, 0);
        check("exhaust_ready", rnd_ready, 1);

        // Starvation: set, survives load, clears, set wins over clear.
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        check("starve_set", starve, 1);
        drive_cycle(1'b1, rand_word(), 1'b0, 1'b0);
        check("starve_hold_load", starve, 1);
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check("starve_clr", starve, 0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        check("starve_set_wins", starve, 1);
        drive_cycle(1'b0, '0, 1'b0, 1'b1);

        // Back-to-back refill at the exhausting adv.
        drive_cycle(1'b1, rand_word(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b1, W'(8'hA5), 1'b1, 1'b0);
        check("b2b_valid", out_valid, 1);
        check("b2b_ch0", shuffle_r[0 +: W], W'(8'hA5));
        check("b2b_reuse", reuse_cnt, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            drive_cycle(($urandom_range(0, 3) != 0), rand_word(),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset while FULL, no clock edge involved.
        drive_cycle(1'b1, rand_word(), 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        rnd_valid = 1'b0; adv = 1'b0; clr_starve = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid",   out_valid, 0);
        check("midrst_shuffle", shuffle_r, 0);
        check("midrst_ready",   rnd_ready, 1);
        check("midrst_reuse",   reuse_cnt, 0);
        check("midrst_starve",  starve,    0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, rand_word(), 1'b0, 1'b0);
        check("post_rst_accept", out_valid, 1);

        // Wrap-around on the W=16 instance.
        s_rnd_valid = 1'b1;
        s_rnd_in    = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        s_rnd_valid = 1'b0;
        check("small_valid", s_out_valid, 1);
        check("small_starve", s_starve, 0);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("wrap_ch0_%0d", j), s_shuffle[15:0],  rotr16(16'h0001, rot_seq[j]));
            check($sformatf("wrap_ch3_%0d", j), s_shuffle[63:48], rotr16(16'h0001, ch3_seq[j]));
            check($sformatf("wrap_reuse_%0d", j), s_reuse, j);
            if (j < 3) begin
                s_adv = 1'b1;
                @(posedge clk);
                @(negedge clk);
                s_adv = 1'b0;
            end
        end
        s_adv = 1'b1;
        #1;
        check("small_ready_exhaust", s_rnd_ready, 1);
        s_adv = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
